// File: rtl/jp_dev.sv
// jp_dev: device-side model of an NES joypad. Answers the console's
// latch/clock/data protocol the way a pad's 4021 shift register does, with
// button state supplied over a parallel write port and optional turbo on A/B.
module jp_dev #(
    parameter int SYNC_STAGES = 2,
    parameter int TURBO_HALF  = 416667,
    parameter int TURBO_W     = 20
) (
    input  logic       clk_in,
    input  logic       nrst_in,
    input  logic       jp_clk_in,
    input  logic       jp_latch_in,
    output logic       jp_data_out,
    input  logic       btn_wr_in,
    input  logic [7:0] btn_d_in,
    input  logic [1:0] turbo_en_in,
    output logic       btn_ack_out,
    output logic [7:0] poll_cnt_out
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        EXHAUST
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] clkSync_q, latchSync_q;
    logic                   clkHist_q, latchHist_q;
    logic                   clkLevel, latchLevel, clkRise, latchFall;

    logic [7:0]         btnReg_q;
    logic               btnAck_q;
    logic [TURBO_W-1:0] turboCnt_q;
    logic               turboPh_q;
    logic               turboWrap;
    logic [7:0]         eff;

    logic [7:0] shreg_q, shreg_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] pollCnt_q, pollCnt_d;
    logic       dataOut_q, dataOut_d;

    // Bring the console's asynchronous clock and latch into our domain, keeping one extra flop for edge detection.
    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            clkSync_q   <= '0;
            latchSync_q <= '0;
            clkHist_q   <= 1'b0;
            latchHist_q <= 1'b0;
        end else begin
            clkSync_q   <= {clkSync_q[SYNC_STAGES-2:0], jp_clk_in};
            latchSync_q <= {latchSync_q[SYNC_STAGES-2:0], jp_latch_in};
            clkHist_q   <= clkSync_q[SYNC_STAGES-1];
            latchHist_q <= latchSync_q[SYNC_STAGES-1];
        end
    end

    assign clkLevel   = clkSync_q[SYNC_STAGES-1];
    assign latchLevel = latchSync_q[SYNC_STAGES-1];
    assign clkRise    = clkLevel & ~clkHist_q;
    assign latchFall  = ~latchLevel & latchHist_q;

    // Capture written button state and acknowledge every write one cycle later.
    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            btnReg_q <= 8'h00;
            btnAck_q <= 1'b0;
        end else begin
            if (btn_wr_in) begin
                btnReg_q <= btn_d_in;
            end
            btnAck_q <= btn_wr_in;
        end
    end

    assign turboWrap = (turboCnt_q == TURBO_W'(TURBO_HALF - 1));

    // Free-running turbo timebase; the phase flips each time the counter wraps.
    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            turboCnt_q <= '0;
            turboPh_q  <= 1'b0;
        end else if (turboWrap) begin
            turboCnt_q <= '0;
            turboPh_q  <= ~turboPh_q;
        end else begin
            turboCnt_q <= turboCnt_q + TURBO_W'(1);
        end
    end

    // Effective pad state: turbo gates A and B with the turbo phase when enabled.
    always_comb begin
        eff    = btnReg_q;
        eff[0] = btnReg_q[0] & (~turbo_en_in[0] | turboPh_q);
        eff[1] = btnReg_q[1] & (~turbo_en_in[1] | turboPh_q);
    end

    // State register.
    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a high latch always wins over a clock edge in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (latchLevel) state_d = LOAD;
            end
            LOAD: begin
                if (latchFall) state_d = SHIFT;
            end
            SHIFT: begin
                if (latchLevel) begin
                    state_d = LOAD;
                end else if (clkRise && (cnt_q == 4'd7)) begin
                    state_d = EXHAUST;
                end
            end
            EXHAUST: begin
                if (latchLevel) state_d = LOAD;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath logic: live load while latched, shift on clock rises, count completed polls.
    always_comb begin
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        pollCnt_d = pollCnt_q;
        if ((state_q == LOAD) || (state_d == LOAD)) begin
            shreg_d = eff;
            cnt_d   = 4'd0;
        end else if ((state_q == SHIFT) && clkRise) begin
            shreg_d = {1'b1, shreg_q[7:1]};
            cnt_d   = cnt_q + 4'd1;
        end
        if ((state_q == LOAD) && (state_d == SHIFT)) begin
            pollCnt_d = pollCnt_q + 8'd1;
        end
        dataOut_d = (state_d == IDLE) ? 1'b1 : ~shreg_d[0];
    end

    // Datapath and output registers.
    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            shreg_q   <= 8'h00;
            cnt_q     <= 4'd0;
            pollCnt_q <= 8'd0;
            dataOut_q <= 1'b1;
        end else begin
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            pollCnt_q <= pollCnt_d;
            dataOut_q <= dataOut_d;
        end
    end

    assign jp_data_out  = dataOut_q;
    assign btn_ack_out  = btnAck_q;
    assign poll_cnt_out = pollCnt_q;

endmodule
